uart_host_bridge: RTL and testbench

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

---
 rtl/uart_host_bridge_if.sv | 47 ++++
 rtl/uart_host_bridge.sv | 158 +++++++++++++++
 tb/tb_uart_host_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_bridge_if.sv
// uart_host_bridge_if
//   Groups the three buses the bridge sits between:
//     S_*  host -> bridge byte stream (bytes to transmit)
//     M_*  bridge -> host byte stream (received bytes plus error flag)
//     U_*  bridge <-> UART strobe/data/status bus (strobes active-low)
//   Modports:
//     master : the bridge (accepts S, drives M, drives the UART strobes)
//     slave  : the environment (host plus UART)
interface uart_host_bridge_if;
    logic [7:0] S_TDATA;
    logic       S_TVALID;
    logic       S_TREADY;

    logic [7:0] M_TDATA;
    logic       M_TERR;
    logic       M_TVALID;
    logic       M_TREADY;

    logic       U_CSN;
    logic       U_WEN;
    logic       U_OEN;
    logic [7:0] U_WDATA;
    logic [7:0] U_RDATA;
    logic       U_TXRDY;
    logic       U_RXRDY;
    logic       U_PARITY_ERR;
    logic       U_FRAMING_ERR;
    logic       U_OVERFLOW;

    modport master (
        input  S_TDATA, S_TVALID,
        output S_TREADY,
        output M_TDATA, M_TERR, M_TVALID,
        input  M_TREADY,
        output U_CSN, U_WEN, U_OEN, U_WDATA,
        input  U_RDATA, U_TXRDY, U_RXRDY, U_PARITY_ERR, U_FRAMING_ERR, U_OVERFLOW
    );

    modport slave (
        output S_TDATA, S_TVALID,
        input  S_TREADY,
        input  M_TDATA, M_TERR, M_TVALID,
        output M_TREADY,
        input  U_CSN, U_WEN, U_OEN, U_WDATA,
        output U_RDATA, U_TXRDY, U_RXRDY, U_PARITY_ERR, U_FRAMING_ERR, U_OVERFLOW
    );
endinterface

// File: rtl/uart_host_bridge.sv
// uart_host_bridge
//   Bridges a host byte-stream pair onto a strobe-based UART register port.
//   One UART access at a time: a write (WR, 1 cycle) or a read (RD for
//   RD_CYC cycles, then CAP to capture the byte), each followed by SETTLE
//   idle cycles before the UART status is sampled again. Reads and writes
//   contending in the same IDLE cycle are served round-robin.
//   Ports:
//     CLK        rising-edge clock
//     RESET      synchronous active-high reset
//     bus        uart_host_bridge_if.master (S stream in, M stream out, UART bus)
//     CLR_STATS  synchronous clear of OVF_CNT/ERR_CNT (wins over increments)
//     OVF_CNT    saturating count of U_OVERFLOW rising edges
//     ERR_CNT    saturating count of bytes popped with M_TERR=1
module uart_host_bridge #(
    parameter int SETTLE_CYC = 2,  // legal 1..7
    parameter int RD_CYC     = 1   // legal 1..3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    uart_host_bridge_if.master   bus,
    input  logic                 CLR_STATS,
    output logic [7:0]           OVF_CNT,
    output logic [7:0]           ERR_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        SETTLE
    } state_t;

    localparam logic [2:0] RD_LAST     = 3'(RD_CYC - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

    state_t     state_q, state_nxt;
    logic [2:0] cnt_q;          // cycles spent in the current RD/SETTLE visit
    logic       last_wr_q;      // 1: the last grant was a write
    logic       csn_q, wen_q, oen_q;
    logic [7:0] wdata_q;
    logic [7:0] m_data_q;
    logic       m_err_q;
    logic       m_valid_q;
    logic       ovf_q;
    logic [7:0] ovf_cnt_q, err_cnt_q;

    logic       rd_pend, wr_pend;
    logic       grant_rd, grant_wr;
    logic       m_pop;

    // A read may only start if the M register will be free when CAP loads it;
    // with a single access outstanding nothing else can refill M meanwhile.
    assign m_pop   = m_valid_q && bus.M_TREADY;
    assign rd_pend = bus.U_RXRDY && (!m_valid_q || bus.M_TREADY);
    assign wr_pend = bus.S_TVALID && bus.U_TXRDY;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state_q;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the class not served last wins.
                if (rd_pend && (!wr_pend || last_wr_q)) begin
                    grant_rd  = 1'b1;
                    state_nxt = RD;
                end else if (wr_pend) begin
                    grant_wr  = 1'b1;
                    state_nxt = WR;
                end
            end
            WR:      state_nxt = SETTLE;
            RD:      if (cnt_q == RD_LAST) state_nxt = CAP;
            CAP:     state_nxt = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The write handshake is only offered outside reset so no byte can be
    // consumed by a cycle whose effects the reset discards.
    assign bus.S_TREADY = grant_wr && !RESET;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            last_wr_q <= 1'b1;
            csn_q     <= 1'b1;
            wen_q     <= 1'b1;
            oen_q     <= 1'b1;
            wdata_q   <= 8'h00;
            m_data_q  <= 8'h00;
            m_err_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= (state_nxt != state_q || state_q == IDLE) ? 3'd0 : cnt_q + 3'd1;

            // Strobes are registered from the next state so they line up
            // exactly with the WR/RD state cycles.
            csn_q <= !(state_nxt == WR || state_nxt == RD);
            wen_q <= (state_nxt != WR);
            oen_q <= (state_nxt != RD);

            if (grant_wr) begin
                wdata_q   <= bus.S_TDATA;
                last_wr_q <= 1'b1;
            end else if (grant_rd) begin
                last_wr_q <= 1'b0;
            end

            // A CAP load replaces a byte popped in the same cycle.
            if (state_q == CAP) begin
                m_data_q  <= bus.U_RDATA;
                m_err_q   <= bus.U_PARITY_ERR | bus.U_FRAMING_ERR;
                m_valid_q <= 1'b1;
            end else if (m_pop) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'h00;
            err_cnt_q <= 8'h00;
        end else begin
            ovf_q <= bus.U_OVERFLOW;
            if (CLR_STATS) begin
                ovf_cnt_q <= 8'h00;
                err_cnt_q <= 8'h00;
            end else begin
                if (bus.U_OVERFLOW && !ovf_q && ovf_cnt_q != 8'hFF)
                    ovf_cnt_q <= ovf_cnt_q + 8'd1;
                if (m_pop && m_err_q && err_cnt_q != 8'hFF)
                    err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.U_CSN    = csn_q;
    assign bus.U_WEN    = wen_q;
    assign bus.U_OEN    = oen_q;
    assign bus.U_WDATA  = wdata_q;
    assign bus.M_TDATA  = m_data_q;
    assign bus.M_TERR   = m_err_q;
    assign bus.M_TVALID = m_valid_q;
    assign OVF_CNT      = ovf_cnt_q;
    assign ERR_CNT      = err_cnt_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge
//   Directed stimulus for uart_host_bridge with scoreboards: expected M bytes
//   and expected UART write bytes are queued when the stimulus is issued and
//   popped by monitors whenever the DUT presents them. Inputs are driven 1
//   time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_host_bridge;

    localparam int SETTLE_CYC = 2;
    localparam int RD_CYC     = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CLR_STATS;
    logic [7:0] OVF_CNT;
    logic [7:0] ERR_CNT;

    uart_host_bridge_if bus ();

    uart_host_bridge #(
        .SETTLE_CYC (SETTLE_CYC),
        .RD_CYC     (RD_CYC)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .CLR_STATS (CLR_STATS),
        .OVF_CNT   (OVF_CNT),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rd     = 0;
    logic [8:0] m_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] grant_log[$];
    logic       prev_oen = 1'b1;
    logic [8:0] exp_m;
    logic [7:0] exp_w;
    logic [7:0] wdat [2] = '{8'hA1, 8'hB2};
    logic [7:0] exp_order [4] = '{"R", "W", "R", "W"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_reads(input int target, input int budget, input string name);
        int k = 0;
        while (n_rd < target && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check(name, 32'(n_rd >= target), 32'd1);
    endtask

    task automatic wait_accept(input string name);
        int k    = 0;
        bit seen = 1'b0;
        while (!seen && k < 30) begin
            @(negedge CLK);
            k++;
            seen = (bus.S_TVALID === 1'b1 && bus.S_TREADY === 1'b1);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Issues one read and leaves the bench at posedge+1 with the FSM idle.
    task automatic do_read(input logic [7:0] d, input logic pe, input logic fe);
        int base = n_rd;
        bus.U_RDATA       = d;
        bus.U_PARITY_ERR  = pe;
        bus.U_FRAMING_ERR = fe;
        m_q.push_back({pe | fe, d});
        bus.U_RXRDY = 1'b1;
        wait_reads(base + 1, 20, "rd_issue");
        @(posedge CLK);
        #1;
        bus.U_RXRDY = 1'b0;
        idle_cycles(5);
        bus.U_PARITY_ERR  = 1'b0;
        bus.U_FRAMING_ERR = 1'b0;
    endtask

    // M stream scoreboard.
    always @(negedge CLK) begin
        if (bus.M_TVALID === 1'b1 && bus.M_TREADY === 1'b1) begin
            if (m_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL m_unexpected: got byte 0x%0h err %0b, expected none", bus.M_TDATA, bus.M_TERR);
            end else begin
                exp_m = m_q.pop_front();
                check("m_byte", 32'({bus.M_TERR, bus.M_TDATA}), 32'(exp_m));
            end
        end
    end

    // UART bus monitor: write scoreboard, grant log, strobe sanity.
    always @(negedge CLK) begin
        if (bus.U_CSN === 1'b0 && bus.U_WEN === 1'b0) begin
            grant_log.push_back("W");
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got write 0x%0h, expected none", bus.U_WDATA);
            end else begin
                exp_w = wr_q.pop_front();
                check("wr_byte", 32'(bus.U_WDATA), 32'(exp_w));
            end
        end
        if (bus.U_OEN === 1'b0 && prev_oen) begin
            n_rd++;
            grant_log.push_back("R");
        end
        prev_oen = (bus.U_OEN !== 1'b0);
        if (bus.U_WEN === 1'b0 || bus.U_OEN === 1'b0) begin
            check("strobe_excl", 32'({bus.U_WEN, bus.U_OEN}), (bus.U_WEN === 1'b0) ? 32'd1 : 32'd2);
            check("strobe_csn", 32'(bus.U_CSN), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  seen;

        // Reset state, with requests pending to show they are held off.
        RESET             = 1'b1;
        CLR_STATS         = 1'b0;
        bus.S_TDATA       = 8'hFF;
        bus.S_TVALID      = 1'b1;
        bus.M_TREADY      = 1'b0;
        bus.U_RDATA       = 8'h00;
        bus.U_TXRDY       = 1'b1;
        bus.U_RXRDY       = 1'b1;
        bus.U_PARITY_ERR  = 1'b0;
        bus.U_FRAMING_ERR = 1'b0;
        bus.U_OVERFLOW    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_csn", 32'(bus.U_CSN), 32'd1);
        check("rst_wen", 32'(bus.U_WEN), 32'd1);
        check("rst_oen", 32'(bus.U_OEN), 32'd1);
        check("rst_wdata", 32'(bus.U_WDATA), 32'h00);
        check("rst_tready", 32'(bus.S_TREADY), 32'd0);
        check("rst_mvalid", 32'(bus.M_TVALID), 32'd0);
        check("rst_mdata", 32'(bus.M_TDATA), 32'h00);
        check("rst_merr", 32'(bus.M_TERR), 32'd0);
        check("rst_ovf", 32'(OVF_CNT), 32'd0);
        check("rst_err", 32'(ERR_CNT), 32'd0);
        @(posedge CLK);
        #1;
        bus.S_TVALID = 1'b0;
        bus.U_TXRDY  = 1'b0;
        bus.U_RXRDY  = 1'b0;
        RESET        = 1'b0;
        idle_cycles(2);

        // Single read: 0xC3, no error, consumer ready.
        bus.U_RDATA  = 8'hC3;
        bus.M_TREADY = 1'b1;
        bus.U_RXRDY  = 1'b1;
        m_q.push_back({1'b0, 8'hC3});
        @(negedge CLK);
        check("rd_grant_oen_high", 32'(bus.U_OEN), 32'd1);
        @(negedge CLK);
        check("rd_oen_low", 32'(bus.U_OEN), 32'd0);
        check("rd_csn_low", 32'(bus.U_CSN), 32'd0);
        check("rd_wen_high", 32'(bus.U_WEN), 32'd1);
        @(posedge CLK);
        #1;
        bus.U_RXRDY = 1'b0;
        @(negedge CLK);
        check("rd_cap_oen_high", 32'(bus.U_OEN), 32'd1);
        check("rd_cap_mvalid", 32'(bus.M_TVALID), 32'd0);
        @(negedge CLK);
        check("rd_mvalid", 32'(bus.M_TVALID), 32'd1);
        check("rd_mdata", 32'(bus.M_TDATA), 32'hC3);
        check("rd_merr", 32'(bus.M_TERR), 32'd0);
        idle_cycles(4);

        // Single write: 0x5A.
        bus.U_TXRDY  = 1'b1;
        bus.S_TDATA  = 8'h5A;
        bus.S_TVALID = 1'b1;
        wr_q.push_back(8'h5A);
        @(negedge CLK);
        check("wr_tready", 32'(bus.S_TREADY), 32'd1);
        check("wr_grant_wen_high", 32'(bus.U_WEN), 32'd1);
        @(posedge CLK);
        #1;
        bus.S_TVALID = 1'b0;
        @(negedge CLK);
        check("wr_csn_low", 32'(bus.U_CSN), 32'd0);
        check("wr_wen_low", 32'(bus.U_WEN), 32'd0);
        check("wr_tready_drop", 32'(bus.S_TREADY), 32'd0);
        for (int i = 0; i < SETTLE_CYC; i++) begin
            @(negedge CLK);
            check("wr_settle_strobes", 32'({bus.U_CSN, bus.U_WEN, bus.U_OEN}), 32'b111);
            check("wr_wdata_hold", 32'(bus.U_WDATA), 32'h5A);
        end
        idle_cycles(2);

        // Contention: read and write pending continuously, read first.
        grant_log.delete();
        base        = n_rd;
        bus.U_RDATA = 8'h3C;
        m_q.push_back({1'b0, 8'h3C});
        m_q.push_back({1'b0, 8'h3C});
        wr_q.push_back(wdat[0]);
        wr_q.push_back(wdat[1]);
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    bus.S_TDATA  = wdat[i];
                    bus.S_TVALID = 1'b1;
                    wait_accept("ct_accept");
                    @(posedge CLK);
                    #1;
                end
                bus.S_TVALID = 1'b0;
            end
            begin
                bus.U_RXRDY = 1'b1;
                wait_reads(base + 2, 40, "ct_reads");
                @(posedge CLK);
                #1;
                bus.U_RXRDY = 1'b0;
            end
        join
        idle_cycles(6);
        check("ct_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size())
                check("ct_grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end

        // Backpressure: M holds 0x11 while a new byte is waiting in the UART.
        bus.M_TREADY = 1'b0;
        do_read(8'h11, 1'b0, 1'b0);
        base        = n_rd;
        bus.U_RDATA = 8'h22;
        bus.U_RXRDY = 1'b1;
        idle_cycles(8);
        check("bp_no_read", 32'(n_rd), 32'(base));
        check("bp_hold_valid", 32'(bus.M_TVALID), 32'd1);
        check("bp_hold_data", 32'(bus.M_TDATA), 32'h11);
        m_q.push_back({1'b0, 8'h22});
        bus.M_TREADY = 1'b1;
        wait_reads(base + 1, 10, "bp_read_after_pop");
        @(posedge CLK);
        #1;
        bus.U_RXRDY = 1'b0;
        idle_cycles(5);
        check("bp_drained", 32'(m_q.size()), 32'd0);

        // Overflow statistics, saturation and clear priority.
        for (int i = 0; i < 300; i++) begin
            bus.U_OVERFLOW = 1'b1;
            idle_cycles(1);
            bus.U_OVERFLOW = 1'b0;
            idle_cycles(1);
            if (i == 99) check("ovf_100", 32'(OVF_CNT), 32'd100);
        end
        check("ovf_sat", 32'(OVF_CNT), 32'd255);
        bus.U_OVERFLOW = 1'b1;
        CLR_STATS      = 1'b1;
        idle_cycles(1);
        CLR_STATS = 1'b0;
        check("ovf_clr_wins", 32'(OVF_CNT), 32'd0);
        idle_cycles(1);
        check("ovf_level_no_count", 32'(OVF_CNT), 32'd0);
        bus.U_OVERFLOW = 1'b0;
        idle_cycles(1);
        bus.U_OVERFLOW = 1'b1;
        idle_cycles(1);
        bus.U_OVERFLOW = 1'b0;
        check("ovf_after_clr", 32'(OVF_CNT), 32'd1);

        // Error statistics: framing error then parity error, then clear.
        do_read(8'h77, 1'b0, 1'b1);
        check("err_framing", 32'(ERR_CNT), 32'd1);
        do_read(8'h44, 1'b1, 1'b0);
        check("err_parity", 32'(ERR_CNT), 32'd2);
        do_read(8'h55, 1'b0, 1'b0);
        check("err_clean", 32'(ERR_CNT), 32'd2);
        CLR_STATS = 1'b1;
        idle_cycles(1);
        CLR_STATS = 1'b0;
        check("clr_err", 32'(ERR_CNT), 32'd0);
        check("clr_ovf", 32'(OVF_CNT), 32'd0);

        // Reset during RD: access aborted, byte discarded, fresh read follows.
        bus.U_RDATA = 8'h99;
        bus.U_RXRDY = 1'b1;
        seen        = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge CLK);
            seen = (bus.U_OEN === 1'b0);
        end
        check("rst_rd_reached", 32'(seen), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_rd_strobes", 32'({bus.U_CSN, bus.U_WEN, bus.U_OEN}), 32'b111);
        check("rst_rd_mvalid", 32'(bus.M_TVALID), 32'd0);
        m_q.push_back({1'b0, 8'h99});
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            if (k > 0) @(negedge CLK);
            seen = (bus.U_OEN === 1'b0);
        end
        check("rst_rd_fresh_read", 32'(seen), 32'd1);
        @(posedge CLK);
        #1;
        bus.U_RXRDY = 1'b0;
        idle_cycles(6);

        check("final_m_q_empty", 32'(m_q.size()), 32'd0);
        check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
